// File: rtl/sram_song_loader.sv
// Purpose: loads a byte stream of 16-bit song words into an async SRAM from address 0 until an END word.
// Latency: two accepted bytes per word, then WE_CYCLES+2 cycles from SETUP entry to the next GET_HI.
// Backpressure: BYTE_READY is high only in GET_HI/GET_LO; bytes are never buffered.
module sram_song_loader #(
  parameter int unsigned WE_CYCLES = 2,
  parameter logic [17:0] MAX_ADDR  = 18'h3FFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  BYTE_DATA,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        SRAM_WE,
  output logic        SRAM_CE,
  output logic        SRAM_OE,
  output logic        SRAM_LB,
  output logic        SRAM_UB,
  output logic [17:0] SRAM_A,
  output logic [15:0] SRAM_DQ_O,
  output logic        SRAM_DQ_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        CPU_HOLD,
  output logic [17:0] WORD_COUNT
);

  typedef enum logic [2:0] {
    IDLE, GET_HI, GET_LO, SETUP, WRITE, HOLD, FIN, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  we_cnt;
  logic [15:0] word;
  logic [17:0] addr;
  logic [17:0] word_cnt;

  logic accept;
  logic restart;
  logic we_last;
  logic is_end;
  logic is_illegal;
  logic at_max;

  assign accept     = BYTE_VALID && BYTE_READY;
  assign restart    = START && (state == IDLE || state == FIN || state == ERR);
  assign we_last    = (we_cnt == 4'(WE_CYCLES - 1));
  assign is_end     = (word[15:12] == 4'b0000);
  assign is_illegal = (word[15:14] == 2'b01);
  assign at_max     = (addr == MAX_ADDR);

  // State register; async reset drops WE immediately because WE decodes from state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    BYTE_READY = 1'b0;
    SRAM_WE    = 1'b1;
    SRAM_DQ_OE = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ERROR      = 1'b0;
    case (state)
      IDLE, FIN, ERR: begin
        if (restart) state_nxt = GET_HI;
        DONE  = (state == FIN);
        ERROR = (state == ERR);
      end
      GET_HI: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (accept) state_nxt = GET_LO;
      end
      GET_LO: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        // High byte already latched, so the opcode check needs only word[15:14].
        if (accept) state_nxt = is_illegal ? ERR : SETUP;
      end
      SETUP: begin
        BUSY       = 1'b1;
        SRAM_DQ_OE = 1'b1;
        state_nxt  = WRITE;
      end
      WRITE: begin
        BUSY       = 1'b1;
        SRAM_DQ_OE = 1'b1;
        SRAM_WE    = 1'b0;
        if (we_last) state_nxt = HOLD;
      end
      HOLD: begin
        BUSY       = 1'b1;
        SRAM_DQ_OE = 1'b1;
        if (is_end)      state_nxt = FIN;
        else if (at_max) state_nxt = ERR;
        else             state_nxt = GET_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: word assembly, write-pulse counter, address and word count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word     <= '0;
      addr     <= '0;
      word_cnt <= '0;
      we_cnt   <= '0;
    end else begin
      case (state)
        IDLE, FIN, ERR: begin
          if (restart) begin
            addr     <= '0;
            word_cnt <= '0;
          end
        end
        GET_HI:  if (accept) word[15:8] <= BYTE_DATA;
        GET_LO:  if (accept) word[7:0]  <= BYTE_DATA;
        SETUP:   we_cnt <= '0;
        WRITE:   we_cnt <= we_cnt + 4'd1;
        HOLD: begin
          word_cnt <= word_cnt + 18'd1;
          // Address only advances when another word follows; no wrap at MAX_ADDR.
          if (!is_end && !at_max) addr <= addr + 18'd1;
        end
        default: ;
      endcase
    end
  end

  assign SRAM_A     = addr;
  assign SRAM_DQ_O  = word;
  assign WORD_COUNT = word_cnt;
  assign SRAM_CE    = 1'b0;
  assign SRAM_LB    = 1'b0;
  assign SRAM_UB    = 1'b0;
  assign SRAM_OE    = BUSY;
  assign CPU_HOLD   = BUSY || ERROR;

endmodule

// File: tb/tb_sram_song_loader.sv
// Purpose: self-checking bench for sram_song_loader against a word-level load model.
// Latency: checks write pulse width, address/data stability and SETUP-to-GET_HI cycle count.
// Backpressure: drives bytes with random gaps and only advances on VALID && READY.
module tb_sram_song_loader;

  localparam int          WE_CYC = 2;
  localparam logic [17:0] MAXA   = 18'd3;

  logic        CLK, RST_N, START, BYTE_VALID, BYTE_READY;
  logic [7:0]  BYTE_DATA;
  logic        SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_DQ_OE;
  logic [17:0] SRAM_A, WORD_COUNT;
  logic [15:0] SRAM_DQ_O;
  logic        BUSY, DONE, ERROR, CPU_HOLD;

  sram_song_loader #(.WE_CYCLES(WE_CYC), .MAX_ADDR(MAXA)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BYTE_DATA(BYTE_DATA),
    .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .SRAM_WE(SRAM_WE), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE),
    .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB), .SRAM_A(SRAM_A),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .CPU_HOLD(CPU_HOLD),
    .WORD_COUNT(WORD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model and observation state, maintained by the monitor
  logic [15:0] mem [int];
  logic [15:0] exp_mem [int];
  logic [7:0]  acc_q [$];
  logic [15:0] words_q [$];
  int          wr_cnt = 0;

  int          cyc = 0;
  int          setup_cyc = -1;
  int          plen = 0;
  bit          in_pulse = 0;
  logic [17:0] p_a, prev_a;
  logic [15:0] p_dq, prev_dq;
  logic        prev_oe = 1'b0, prev_rdy = 1'b0;

  // Monitor: SRAM write capture, pulse shape, A/DQ stability, write-to-next-byte latency
  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      in_pulse  = 0;
      setup_cyc = -1;
    end else begin
      if (!SRAM_WE) begin
        if (!in_pulse) begin
          in_pulse = 1;
          plen     = 0;
          p_a      = SRAM_A;
          p_dq     = SRAM_DQ_O;
          chk("setup_a", SRAM_A, prev_a);
          chk("setup_dq", SRAM_DQ_O, prev_dq);
        end
        plen++;
        chk("we_a", SRAM_A, p_a);
        chk("we_dq", SRAM_DQ_O, p_dq);
        chk("we_dq_oe", SRAM_DQ_OE, 1);
      end else if (in_pulse) begin
        in_pulse = 0;
        chk("we_len", plen, WE_CYC);
        chk("hold_a", SRAM_A, p_a);
        chk("hold_dq", SRAM_DQ_O, p_dq);
        chk("hold_dq_oe", SRAM_DQ_OE, 1);
        mem[int'(p_a)] = p_dq;
        wr_cnt++;
      end
      if (SRAM_DQ_OE && !prev_oe) setup_cyc = cyc;
      if (BYTE_READY && !prev_rdy && setup_cyc >= 0) begin
        chk("setup_to_ready", cyc - setup_cyc, WE_CYC + 2);
        setup_cyc = -1;
      end
      if (DONE || ERROR) setup_cyc = -1;
      if (BYTE_VALID && BYTE_READY) acc_q.push_back(BYTE_DATA);
    end
    prev_a   = SRAM_A;
    prev_dq  = SRAM_DQ_O;
    prev_oe  = SRAM_DQ_OE;
    prev_rdy = BYTE_READY;
  end

  // Word-level model: st 0 = still loading, 1 = finished, 2 = error
  task automatic model(output int st, output int cnt, output logic [17:0] a, output int nused);
    exp_mem.delete();
    a = '0; cnt = 0; st = 0; nused = 0;
    foreach (words_q[i]) begin
      if (st != 0) break;
      nused++;
      if (words_q[i][15:14] == 2'b01) st = 2;
      else begin
        exp_mem[int'(a)] = words_q[i];
        cnt++;
        if (words_q[i][15:12] == 4'h0) st = 1;
        else if (a == MAXA)            st = 2;
        else                           a = a + 18'd1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, SRAM_WE, 1);
    chk({tag, "_dq_oe"}, SRAM_DQ_OE, 0);
    chk({tag, "_oe"}, SRAM_OE, 0);
    chk({tag, "_a"}, SRAM_A, 0);
    chk({tag, "_dq"}, SRAM_DQ_O, 0);
    chk({tag, "_wc"}, WORD_COUNT, 0);
    chk({tag, "_flags"}, {BUSY, DONE, ERROR, CPU_HOLD, BYTE_READY}, 5'b00000);
  endtask

  // Runs one load of words_q (truncated where the model stops), then checks all results
  task automatic run_load(input bit gaps, input bit start_mid, input string name);
    int st, cnt, nused, idx, n;
    logic [17:0] ea;
    logic [7:0] bq [$];
    bit acc, p_rdy, p_acc, mid_done, fin;
    model(st, cnt, ea, nused);
    if (st == 0) begin
      words_q.push_back(16'h0000);
      model(st, cnt, ea, nused);
    end
    bq.delete();
    for (int i = 0; i < nused; i++) begin
      bq.push_back(words_q[i][15:8]);
      bq.push_back(words_q[i][7:0]);
    end
    n = bq.size();
    mem.delete();
    wr_cnt = 0;
    acc_q.delete();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    idx = 0; p_rdy = 0; p_acc = 0; mid_done = 0; fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (start_mid && !mid_done && p_rdy && !p_acc && idx > 0) begin
        START      = 1'b1;
        BYTE_VALID = 1'b0;
        BYTE_DATA  = 8'($urandom);
        mid_done   = 1;
      end else begin
        START      = 1'b0;
        BYTE_VALID = (idx < n) && !(gaps && $urandom_range(0, 2) == 0);
        BYTE_DATA  = (idx < n) ? bq[idx] : 8'($urandom);
      end
      @(negedge CLK);
      acc   = BYTE_VALID && BYTE_READY;
      p_rdy = BYTE_READY;
      p_acc = acc;
      fin   = DONE || ERROR;
      if (!fin) begin
        @(posedge CLK); #1;
        if (acc) idx++;
      end
    end
    if (!fin) chk({name, "_timeout"}, 0, 1);
    chk({name, "_done"}, DONE, st == 1);
    chk({name, "_error"}, ERROR, st == 2);
    chk({name, "_wc"}, WORD_COUNT, cnt);
    chk({name, "_a"}, SRAM_A, ea);
    chk({name, "_cpu_hold"}, CPU_HOLD, st == 2);
    chk({name, "_idle_ctl"}, {BUSY, SRAM_OE, SRAM_WE, SRAM_DQ_OE, BYTE_READY}, 5'b00100);
    chk({name, "_ce_lb_ub"}, {SRAM_CE, SRAM_LB, SRAM_UB}, 3'b000);
    chk({name, "_nbytes"}, acc_q.size(), n);
    for (int i = 0; i < n; i++)
      chk({name, "_byte"}, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(bq[i]));
    chk({name, "_writes"}, wr_cnt, cnt);
    foreach (exp_mem[k])
      chk({name, "_mem"}, mem.exists(k) ? 32'(mem[k]) : 32'hDEAD_BEEF, 32'(exp_mem[k]));
    @(posedge CLK); #1;
    BYTE_VALID = 1'b0;
    START      = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    int k;
    logic [7:0] hi;
    k = $urandom_range(0, 99);
    if (k < 12)      hi = {4'h0, 4'($urandom)};
    else if (k < 22) hi = {2'b01, 6'($urandom)};
    else begin
      hi = 8'($urandom);
      while (hi[7:6] == 2'b01 || hi[7:4] == 4'h0) hi = 8'($urandom);
    end
    return {hi, 8'($urandom)};
  endfunction

  initial begin
    logic [7:0] rb [2];
    int  ridx;
    bit  found, racc;

    RST_N = 1'b0; START = 1'b0; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00;
    repeat (2) @(negedge CLK);
    check_reset_outputs("por");
    RST_N = 1'b1;

    // BYTE_VALID in IDLE must not be taken
    acc_q.delete();
    @(posedge CLK); #1 BYTE_VALID = 1'b1; BYTE_DATA = 8'h5A;
    repeat (3) @(negedge CLK);
    chk("idle_ready", BYTE_READY, 0);
    chk("idle_accepts", acc_q.size(), 0);
    @(posedge CLK); #1 BYTE_VALID = 1'b0;

    words_q = '{16'h9123, 16'h1060, 16'h0000};
    run_load(0, 0, "basic");
    chk("basic_w0", mem.exists(0) ? 32'(mem[0]) : 32'hDEAD_BEEF, 32'h9123);
    chk("basic_w1", mem.exists(1) ? 32'(mem[1]) : 32'hDEAD_BEEF, 32'h1060);
    chk("basic_w2", mem.exists(2) ? 32'(mem[2]) : 32'hDEAD_BEEF, 32'h0000);
    chk("basic_status", {DONE, ERROR, WORD_COUNT, SRAM_A}, {1'b1, 1'b0, 18'd3, 18'd2});

    words_q = '{16'h4500};
    run_load(0, 0, "illegal");
    chk("illegal_status", {ERROR, CPU_HOLD, WORD_COUNT}, {1'b1, 1'b1, 18'd0});
    chk("illegal_no_we", wr_cnt, 0);

    words_q = '{16'h8001, 16'h8001, 16'h8001, 16'h8001};
    run_load(0, 0, "overflow");
    chk("overflow_status", {ERROR, SRAM_A, WORD_COUNT}, {1'b1, 18'd3, 18'd4});
    chk("overflow_writes", wr_cnt, 4);

    words_q = '{16'hA5C3, 16'h2001, 16'h0ABC};
    run_load(1, 1, "gap_start");

    // Reset in the second WRITE cycle
    rb[0] = 8'h80; rb[1] = 8'h01;
    ridx = 0; found = 0;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      BYTE_VALID = (ridx < 2);
      BYTE_DATA  = (ridx < 2) ? rb[ridx] : 8'h00;
      @(negedge CLK);
      racc = BYTE_VALID && BYTE_READY;
      if (!SRAM_WE) found = 1;
      else begin
        @(posedge CLK); #1;
        if (racc) ridx++;
      end
    end
    if (!found) chk("rst_test_timeout", 0, 1);
    BYTE_VALID = 1'b0;
    @(posedge CLK); #2;
    chk("rst_pre_we", SRAM_WE, 0);
    RST_N = 1'b0;
    #1;
    chk("rst_async_we", SRAM_WE, 1);
    chk("rst_async_dq_oe", SRAM_DQ_OE, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("post_rst");

    for (int t = 0; t < 10; t++) begin
      words_q.delete();
      for (int w = 0; w < 6; w++) words_q.push_back(rand_word());
      run_load(1'($urandom), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
